fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/common.sv | 20 ++
 rtl/fetch_perf.sv | 28 ++
 rtl/fetch_unit.sv | 146 ++++++++++++++
 tb/tb_fetch_unit.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/common.sv
// Shared fetch types and constants: word/instruction types, fetch FSM states, reset/exception vectors.
package common;

   typedef logic [31:0] word_t;
   typedef logic [31:0] instr_t;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DRAIN = 2'd2
   } fetch_state_t;

   localparam word_t BOOT_PC_DEFAULT = 32'h0000_1000;
   localparam word_t EXC_PC_DEFAULT  = 32'h0000_2000;

   function automatic word_t word_align(input word_t a);
      return {a[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_perf.sv
// Fetch performance counters: instructions accepted by decode, cycles spent waiting on the icache.
// Latency: counters update one edge after the event. Backpressure: none, observes only; wraps at 2^32.
module fetch_perf (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_fetched,
   input  logic        i_miss,
   output logic [31:0] perf_fetched_o,
   output logic [31:0] perf_miss_cycles_o
);

   logic [31:0] r_fetched;
   logic [31:0] r_miss;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fetched <= '0;
         r_miss    <= '0;
      end else begin
         if (i_fetched) r_fetched <= r_fetched + 32'd1;
         if (i_miss)    r_miss    <= r_miss + 32'd1;
      end
   end

   assign perf_fetched_o     = r_fetched;
   assign perf_miss_cycles_o = r_miss;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: icache request FSM, one-entry skid buffer and fetch/decode register; FETCH_PERF_CNT_EN adds counters.
// Latency: one cycle from icache transfer to valid_o. Backpressure: stall_i freezes the output register, one extra fetch parks in the skid.
module fetch_unit
   import common::*;
#(
   parameter word_t BOOT_PC = BOOT_PC_DEFAULT,
   parameter word_t EXC_PC  = EXC_PC_DEFAULT
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   stall_i,
   input  logic   redirect_valid_i,
   input  word_t  redirect_pc_i,
   input  logic   exc_valid_i,
   input  logic   iret_valid_i,
   input  word_t  iret_pc_i,
   output logic   ic_req_o,
   output word_t  ic_addr_o,
   input  logic   ic_ready_i,
   input  instr_t ic_data_i,
   output instr_t instr_o,
   output word_t  pc_o,
   output logic   valid_o
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] perf_fetched_o,
   output logic [31:0] perf_miss_cycles_o
`endif
);

   fetch_state_t r_state, w_state_nxt;
   word_t  r_pc, w_pc_nxt;
   word_t  r_drain_addr, w_drain_addr_nxt;
   word_t  r_skid_pc, w_skid_pc_nxt;
   instr_t r_skid_instr, w_skid_instr_nxt;
   word_t  r_pc_out, w_pc_out_nxt;
   instr_t r_instr, w_instr_nxt;
   logic   r_valid, w_valid_nxt;
   logic   w_flush;
   logic   w_xfer;
   word_t  w_target;

   // Request is gated by rst_n so it drops the moment reset asserts.
   assign ic_req_o  = rst_n && (r_state != HOLD);
   assign ic_addr_o = (r_state == DRAIN) ? r_drain_addr : r_pc;
   assign w_xfer    = ic_req_o && ic_ready_i;
   assign w_flush   = exc_valid_i || iret_valid_i || redirect_valid_i;

   always_comb begin
      w_target = word_align(redirect_pc_i);
      if (exc_valid_i)       w_target = EXC_PC;
      else if (iret_valid_i) w_target = word_align(iret_pc_i);
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_pc_nxt         = r_pc;
      w_drain_addr_nxt = r_drain_addr;
      w_skid_pc_nxt    = r_skid_pc;
      w_skid_instr_nxt = r_skid_instr;
      w_pc_out_nxt     = r_pc_out;
      w_instr_nxt      = r_instr;
      w_valid_nxt      = r_valid;
      case (r_state)
         FETCH: begin
            if (w_flush) begin
               w_valid_nxt = 1'b0;
               w_pc_nxt    = w_target;
               // An unanswered request must still complete at its original address.
               if (!w_xfer) begin
                  w_state_nxt      = DRAIN;
                  w_drain_addr_nxt = r_pc;
               end
            end else if (w_xfer) begin
               w_pc_nxt = r_pc + 32'd4;
               if (stall_i) begin
                  w_skid_pc_nxt    = r_pc;
                  w_skid_instr_nxt = ic_data_i;
                  w_state_nxt      = HOLD;
               end else begin
                  w_pc_out_nxt = r_pc;
                  w_instr_nxt  = ic_data_i;
                  w_valid_nxt  = 1'b1;
               end
            end else if (!stall_i) begin
               w_valid_nxt = 1'b0;
            end
         end
         HOLD: begin
            if (w_flush) begin
               w_valid_nxt = 1'b0;
               w_pc_nxt    = w_target;
               w_state_nxt = FETCH;
            end else if (!stall_i) begin
               w_pc_out_nxt = r_skid_pc;
               w_instr_nxt  = r_skid_instr;
               w_valid_nxt  = 1'b1;
               w_state_nxt  = FETCH;
            end
         end
         DRAIN: begin
            if (w_flush) w_pc_nxt = w_target;
            if (w_xfer)  w_state_nxt = FETCH;
         end
         default: w_state_nxt = FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= FETCH;
         r_pc         <= BOOT_PC;
         r_drain_addr <= '0;
         r_skid_pc    <= '0;
         r_skid_instr <= '0;
         r_pc_out     <= '0;
         r_instr      <= '0;
         r_valid      <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_pc         <= w_pc_nxt;
         r_drain_addr <= w_drain_addr_nxt;
         r_skid_pc    <= w_skid_pc_nxt;
         r_skid_instr <= w_skid_instr_nxt;
         r_pc_out     <= w_pc_out_nxt;
         r_instr      <= w_instr_nxt;
         r_valid      <= w_valid_nxt;
      end
   end

   assign instr_o = r_instr;
   assign pc_o    = r_pc_out;
   assign valid_o = r_valid;

`ifdef FETCH_PERF_CNT_EN
   fetch_perf u_fetch_perf (
      .clk                (clk),
      .rst_n              (rst_n),
      .i_fetched          (r_valid && !stall_i),
      .i_miss             (ic_req_o && !ic_ready_i),
      .perf_fetched_o     (perf_fetched_o),
      .perf_miss_cycles_o (perf_miss_cycles_o)
   );
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios then random traffic against a behavioural model.
module tb_fetch_unit;
   import common::*;

   logic   clk = 1'b0;
   logic   rst_n;
   logic   stall_i, redirect_valid_i, exc_valid_i, iret_valid_i, ic_ready_i;
   word_t  redirect_pc_i, iret_pc_i, ic_addr_o, pc_o;
   instr_t ic_data_i, instr_o;
   logic   ic_req_o, valid_o;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetched_o, perf_miss_cycles_o;
`endif

   fetch_unit dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .stall_i          (stall_i),
      .redirect_valid_i (redirect_valid_i),
      .redirect_pc_i    (redirect_pc_i),
      .exc_valid_i      (exc_valid_i),
      .iret_valid_i     (iret_valid_i),
      .iret_pc_i        (iret_pc_i),
      .ic_req_o         (ic_req_o),
      .ic_addr_o        (ic_addr_o),
      .ic_ready_i       (ic_ready_i),
      .ic_data_i        (ic_data_i),
      .instr_o          (instr_o),
      .pc_o             (pc_o),
      .valid_o          (valid_o)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_fetched_o     (perf_fetched_o),
      .perf_miss_cycles_o (perf_miss_cycles_o)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Cache contents: fixed scramble of the address.
   function automatic instr_t mem_word(input word_t a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   // Model: next fetch address, optional parked instruction, optional abandoned request still in flight.
   word_t m_pc, m_drain_addr, m_skid_pc, m_out_pc;
   bit    m_hold, m_drain, m_valid;
   logic [31:0] m_fetched, m_miss;

   task automatic model_reset();
      m_pc = 32'h0000_1000; m_drain_addr = '0; m_skid_pc = '0; m_out_pc = '0;
      m_hold = 0; m_drain = 0; m_valid = 0; m_fetched = '0; m_miss = '0;
   endtask

   // Called at posedge+1; checks at the falling edge, then advances the model across the rising edge.
   task automatic cycle(input bit stall, input bit rdy, input bit exc, input bit iret,
                        input bit red, input word_t ipc, input word_t rpc);
      bit    exp_req, xfer, flush;
      word_t exp_addr, tgt;
      exp_req  = !m_hold;
      exp_addr = m_drain ? m_drain_addr : m_pc;
      stall_i = stall; ic_ready_i = rdy; exc_valid_i = exc; iret_valid_i = iret;
      redirect_valid_i = red; iret_pc_i = ipc; redirect_pc_i = rpc;
      ic_data_i = rdy ? mem_word(exp_addr) : instr_t'($urandom());
      #4;
      check("ic_req_o", ic_req_o, exp_req);
      if (exp_req) check("ic_addr_o", ic_addr_o, exp_addr);
      check("valid_o", valid_o, m_valid);
      if (m_valid) begin
         check("pc_o", pc_o, m_out_pc);
         check("instr_o", instr_o, mem_word(m_out_pc));
      end
`ifdef FETCH_PERF_CNT_EN
      check("perf_fetched", perf_fetched_o, m_fetched);
      check("perf_miss", perf_miss_cycles_o, m_miss);
`endif
      if (m_valid && !stall) m_fetched = m_fetched + 1;
      if (exp_req && !rdy)   m_miss = m_miss + 1;
      xfer  = exp_req && rdy;
      flush = exc || iret || red;
      tgt   = exc ? 32'h0000_2000 : iret ? (ipc & 32'hFFFF_FFFC) : (rpc & 32'hFFFF_FFFC);
      if (m_drain) begin
         if (flush) m_pc = tgt;
         if (xfer)  m_drain = 0;
      end else if (m_hold) begin
         if (flush) begin
            m_valid = 0; m_hold = 0; m_pc = tgt;
         end else if (!stall) begin
            m_out_pc = m_skid_pc; m_valid = 1; m_hold = 0;
         end
      end else if (flush) begin
         m_valid = 0;
         if (!xfer) begin
            m_drain = 1; m_drain_addr = m_pc;
         end
         m_pc = tgt;
      end else if (xfer) begin
         if (stall) begin
            m_hold = 1; m_skid_pc = m_pc;
         end else begin
            m_out_pc = m_pc; m_valid = 1;
         end
         m_pc = m_pc + 32'd4;
      end else if (!stall) begin
         m_valid = 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n, input bit stall, input bit rdy);
      for (int i = 0; i < n; i++) cycle(stall, rdy, 0, 0, 0, '0, '0);
   endtask

   // Asserts reset off-edge, checks the asynchronous effect, releases away from the edge.
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check("rst_valid_o", valid_o, 1'b0);
      check("rst_ic_req_o", ic_req_o, 1'b0);
      check("rst_pc_o", pc_o, 32'h0);
      check("rst_instr_o", instr_o, 32'h0);
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; stall_i = 0; redirect_valid_i = 0; exc_valid_i = 0; iret_valid_i = 0;
      ic_ready_i = 0; redirect_pc_i = '0; iret_pc_i = '0; ic_data_i = '0;
      @(posedge clk);
      #1;
      do_reset();

      // Full hit rate from boot.
      check("boot_addr", ic_addr_o, 32'h0000_1000);
      cycle(0, 1, 0, 0, 0, '0, '0);
      check("first_pc_o", pc_o, 32'h0000_1000);
      check("first_valid", valid_o, 1'b1);
      // Three miss cycles at 0x1004.
      run(3, 0, 0);
      check("miss_addr_stable", ic_addr_o, 32'h0000_1004);
      cycle(0, 1, 0, 0, 0, '0, '0);
      // Stall on the transfer of 0x1008.
      cycle(1, 1, 0, 0, 0, '0, '0);
      check("hold_req", ic_req_o, 1'b0);
      check("hold_frozen_pc_o", pc_o, 32'h0000_1004);
      cycle(1, 1, 0, 0, 0, '0, '0);
      cycle(0, 1, 0, 0, 0, '0, '0);
      check("skid_pc_o", pc_o, 32'h0000_1008);
      check("resume_addr", ic_addr_o, 32'h0000_100C);
      // Redirect while a miss is pending at 0x100C.
      cycle(0, 0, 0, 0, 1, '0, 32'h0000_2040);
      check("drain_old_addr", ic_addr_o, 32'h0000_100C);
      cycle(0, 0, 0, 0, 0, '0, '0);
      cycle(0, 1, 0, 0, 0, '0, '0);
      check("drain_valid", valid_o, 1'b0);
      check("redirect_addr", ic_addr_o, 32'h0000_2040);
      // Exception beats a coincident redirect.
      cycle(0, 1, 1, 0, 1, '0, 32'h0000_3000);
      check("exc_priority", ic_addr_o, 32'h0000_2000);
      // Misaligned target and pc wrap.
      cycle(0, 1, 0, 0, 1, '0, 32'h0000_4003);
      check("align_addr", ic_addr_o, 32'h0000_4000);
      cycle(0, 1, 0, 1, 0, 32'hFFFF_FFFE, '0);
      cycle(0, 1, 0, 0, 0, '0, '0);
      check("wrap_addr", ic_addr_o, 32'h0000_0000);
      // Reset while in HOLD.
      run(2, 0, 1);
      cycle(1, 1, 0, 0, 0, '0, '0);
      check("pre_reset_hold", ic_req_o, 1'b0);
      do_reset();
      check("post_reset_addr", ic_addr_o, 32'h0000_1000);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 599) == 0) begin
            do_reset();
         end else begin
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 49) == 0, $urandom_range(0, 29) == 0,
                  $urandom_range(0, 14) == 0, word_t'($urandom()), word_t'($urandom()));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
